// File: rtl/cx_arb_pkg.sv
// Shared types and constants for the CX requester arbiter.
// Holds the FSM state encoding, CX field widths, the timeout status code
// and the round-robin wrap helper used when advancing the pointer.
package cx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    ERR       = 2'd3
  } cx_state_e;

  localparam int CX_ID_W   = 2;
  localparam int CX_DATA_W = 32;
  localparam int CX_STAT_W = 4;

  localparam logic [CX_STAT_W-1:0] CX_STATUS_TIMEOUT = 4'hF;

  // Successor of idx in 0..n-1. An explicit compare is used so that a
  // non-power-of-two requester count wraps correctly.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cx_rr_picker.sv
// Round-robin picker: finds the first valid requester at or above rr_ptr,
// wrapping back to 0. Purely combinational.
module cx_rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan N_REQ slots starting at rr_ptr; the first valid one wins.
  always_comb begin : pick
    int c;
    c   = 0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!any && req_valid[c]) begin
        any = 1'b1;
        idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/cx_req_arbiter.sv
// CX request arbiter: shares one CX switch port between N_REQ requesters.
// Round-robin grant, one transaction in flight; the grant is held from
// request acceptance until the response handshake completes.
// Optional feature macro CX_TIMEOUT_EN adds a response watchdog that
// answers the requester with CX_STATUS_TIMEOUT and drains a late response.
module cx_req_arbiter
  import cx_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [CX_ID_W*N_REQ-1:0]   req_cxu_id,
  input  logic [CX_ID_W*N_REQ-1:0]   req_state_id,
  input  logic [CX_DATA_W*N_REQ-1:0] req_data0,
  input  logic [CX_DATA_W*N_REQ-1:0] req_data1,
  output logic [N_REQ-1:0]           resp_valid,
  input  logic [N_REQ-1:0]           resp_ready,
  output logic [CX_STAT_W*N_REQ-1:0] resp_status,
  output logic [CX_DATA_W*N_REQ-1:0] resp_data,
  output logic                       m_req_valid,
  input  logic                       m_req_ready,
  output logic [CX_ID_W-1:0]         m_cxu_id,
  output logic [CX_ID_W-1:0]         m_state_id,
  output logic [CX_DATA_W-1:0]       m_data0,
  output logic [CX_DATA_W-1:0]       m_data1,
  input  logic                       m_resp_valid,
  output logic                       m_resp_ready,
  input  logic [CX_STAT_W-1:0]       m_resp_status,
  input  logic [CX_DATA_W-1:0]       m_resp_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("cx_req_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  cx_state_e        state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_nxt;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             accept;

  cx_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any       (pick_any),
    .idx       (pick_idx)
  );

  assign accept      = (state == IDLE) && pick_any;
  assign rr_nxt      = IDX_W'(rr_wrap(int'(grant_id), N_REQ));
  assign m_req_valid = (state == ISSUE);

`ifdef CX_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        stray_pend;

  assign tmo_hit = (state == WAIT_RESP) && !(m_resp_valid && m_resp_ready) &&
                   (tmo_cnt == 16'(TIMEOUT_CYC - 1));

  // Watchdog: cleared when the request is handed to the switch, counts while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE && m_req_ready) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_RESP) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // A timed-out transaction may still be answered later; remember to swallow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stray_pend <= 1'b0;
    end else if (tmo_hit) begin
      stray_pend <= 1'b1;
    end else if (stray_pend && state != WAIT_RESP && m_resp_valid) begin
      stray_pend <= 1'b0;
    end
  end
`endif

  // Transaction FSM with round-robin pointer and grant tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= ISSUE;
            grant_id <= pick_idx;
          end
        end
        ISSUE: begin
          if (m_req_ready) state <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (m_resp_valid && m_resp_ready) begin
            state  <= IDLE;
            rr_ptr <= rr_nxt;
          end
`ifdef CX_TIMEOUT_EN
          else if (tmo_hit) begin
            state <= ERR;
          end
`endif
        end
`ifdef CX_TIMEOUT_EN
        ERR: begin
          if (resp_ready[grant_id]) begin
            state  <= IDLE;
            rr_ptr <= rr_nxt;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the granted requester's payload at acceptance so it can drop valid afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_cxu_id   <= '0;
      m_state_id <= '0;
      m_data0    <= '0;
      m_data1    <= '0;
    end else if (accept) begin
      m_cxu_id   <= req_cxu_id[int'(pick_idx)*CX_ID_W +: CX_ID_W];
      m_state_id <= req_state_id[int'(pick_idx)*CX_ID_W +: CX_ID_W];
      m_data0    <= req_data0[int'(pick_idx)*CX_DATA_W +: CX_DATA_W];
      m_data1    <= req_data1[int'(pick_idx)*CX_DATA_W +: CX_DATA_W];
    end
  end

  // Upstream accept and response routing to the granted slot only.
  always_comb begin
    req_ready    = '0;
    resp_valid   = '0;
    resp_status  = '0;
    resp_data    = '0;
    m_resp_ready = 1'b0;
    if (accept) req_ready[pick_idx] = 1'b1;
    if (state == WAIT_RESP) begin
      resp_valid[grant_id] = m_resp_valid;
      m_resp_ready         = resp_ready[grant_id];
      resp_status[int'(grant_id)*CX_STAT_W +: CX_STAT_W] = m_resp_status;
      resp_data[int'(grant_id)*CX_DATA_W +: CX_DATA_W]   = m_resp_data;
    end
`ifdef CX_TIMEOUT_EN
    if (state == ERR) begin
      resp_valid[grant_id] = 1'b1;
      resp_status[int'(grant_id)*CX_STAT_W +: CX_STAT_W] = CX_STATUS_TIMEOUT;
    end
    if (stray_pend && state != WAIT_RESP) m_resp_ready = 1'b1;
`endif
  end

endmodule
